regfile_scoreboard: RTL and testbench

- Parametrised register file for the ID stage: NUM_RD read ports, one write-back port, and a per-register pending-write scoreboard.
- Generates the read-after-write hazard internally. The ID stage no longer needs an external hazard unit for register operands.
- Adds write-through bypass (same-cycle write-back visible on read ports), multiple in-flight writes per register, pipeline flush and an underflow error flag.
- Sits between instruction decode and the ID/EX pipeline register.

---
 rtl/regfile_scoreboard_pkg.sv | 17 +
 rtl/regfile_scoreboard_counter.sv | 36 +++
 rtl/regfile_scoreboard.sv | 108 ++++++++++
 tb/tb_regfile_scoreboard.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_scoreboard_pkg.sv
// Shared defaults for the ID-stage register file and pending-write scoreboard.
// The saturation helper keeps ID and hazard logic agreeing on counter limits.
package regfile_scoreboard_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int NUM_REGS_DEF = 16;
  localparam int ADDR_W_DEF   = 4;
  localparam int NUM_RD_DEF   = 2;
  localparam int CNT_W_DEF    = 2;

  function automatic int cnt_max(input int w);
    return (1 << w) - 1;
  endfunction

  localparam int CNT_MAX_DEF = cnt_max(CNT_W_DEF);

endpackage

// File: rtl/regfile_scoreboard_counter.sv
// Per-register in-flight write counter.
// Clear wins over inc/dec; simultaneous inc and dec hold the count.
module sb_counter
  import regfile_scoreboard_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  input  logic clr,
  output logic zero,
  output logic one,
  output logic full
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !dec) begin
      cnt <= cnt + CNT_W'(1);
    end else if (dec && !inc) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);
  assign one  = (cnt == CNT_W'(1));
  assign full = (cnt == CNT_W'(cnt_max(CNT_W)));

endmodule

// File: rtl/regfile_scoreboard.sv
// ID-stage register file with write-through bypass and per-register
// pending-write scoreboard that raises read-after-write hazards.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = NUM_RD_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_pending,
  output logic                     hazard,
  input  logic                     issue_valid,
  input  logic [ADDR_W-1:0]        issue_dest,
  output logic                     issue_ready,
  input  logic                     wb_en,
  input  logic [ADDR_W-1:0]        wb_dest,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     flush,
  output logic                     sb_err
);

  localparam int NUM_IDX = 1 << ADDR_W;

  logic [DATA_W-1:0] rf [NUM_IDX];
  logic [NUM_IDX-1:0] zero_v;
  logic [NUM_IDX-1:0] one_v;
  logic [NUM_IDX-1:0] full_v;
  logic [NUM_IDX-1:0] valid_v;

  // Indices past NUM_REGS look like empty, never-pending registers.
  for (genvar r = 0; r < NUM_IDX; r++) begin : g_reg
    if (r < NUM_REGS) begin : g_live
      logic [DATA_W-1:0] q;
      logic hit;
      logic inc;
      logic dec;

      assign hit = wb_en && (wb_dest == ADDR_W'(r));
      assign inc = issue_valid && issue_ready
                && (issue_dest == ADDR_W'(r));
      assign dec = hit && !zero_v[r];

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          q <= '0;
        end else if (hit) begin
          q <= wb_data;
        end
      end

      sb_counter #(
        .CNT_W(CNT_W)
      ) u_cnt (
        .clk (clk),
        .rst (rst),
        .inc (inc),
        .dec (dec),
        .clr (flush),
        .zero(zero_v[r]),
        .one (one_v[r]),
        .full(full_v[r])
      );

      assign rf[r]      = q;
      assign valid_v[r] = 1'b1;
    end else begin : g_none
      assign rf[r]      = '0;
      assign zero_v[r]  = 1'b1;
      assign one_v[r]   = 1'b0;
      assign full_v[r]  = 1'b0;
      assign valid_v[r] = 1'b0;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic wb_hit;

    assign a      = rd_addr[i*ADDR_W +: ADDR_W];
    assign wb_hit = wb_en && (wb_dest == a) && valid_v[a];

    assign rd_data[i*DATA_W +: DATA_W] = wb_hit ? wb_data : rf[a];
    // Last outstanding write arriving now is bypassed; older ones still stall.
    assign rd_pending[i] = rd_en[i] && !zero_v[a]
                        && !(wb_hit && one_v[a]);
  end

  assign hazard = |rd_pending;

  assign issue_ready = !full_v[issue_dest]
                    || (wb_en && (wb_dest == issue_dest));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_err <= 1'b0;
    end else if (wb_en && zero_v[wb_dest] && !flush) begin
      sb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scenario bench for regfile_scoreboard with three read ports.
// Expected values are queued with the stimulus and popped at sample time.
module tb_regfile_scoreboard;

  logic        clk;
  logic        rst;
  logic [2:0]  rd_en;
  logic [11:0] rd_addr;
  logic [95:0] rd_data;
  logic [2:0]  rd_pending;
  logic        hazard;
  logic        issue_valid;
  logic [3:0]  issue_dest;
  logic        issue_ready;
  logic        wb_en;
  logic [3:0]  wb_dest;
  logic [31:0] wb_data;
  logic        flush;
  logic        sb_err;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] sbq[$];
  logic [31:0] e;

  regfile_scoreboard #(
    .DATA_W  (32),
    .NUM_REGS(16),
    .ADDR_W  (4),
    .NUM_RD  (3),
    .CNT_W   (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_pending (rd_pending),
    .hazard     (hazard),
    .issue_valid(issue_valid),
    .issue_dest (issue_dest),
    .issue_ready(issue_ready),
    .wb_en      (wb_en),
    .wb_dest    (wb_dest),
    .wb_data    (wb_data),
    .flush      (flush),
    .sb_err     (sb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    issue_valid = 1'b0;
    wb_en       = 1'b0;
    flush       = 1'b0;
    rd_en       = 3'b000;
  endtask

  task automatic wb(input logic [3:0] d, input logic [31:0] v);
    wb_en   = 1'b1;
    wb_dest = d;
    wb_data = v;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    idle();
    rd_addr = '0; issue_dest = '0;
    wb_dest = '0; wb_data = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    wb(4'd3, 32'h55);
    cyc();
    idle();
    rd_addr = {4'd0, 4'd0, 4'd3};
    rd_en   = 3'b001;
    sbq.push_back(32'h55);
    #1;
    e = sbq.pop_front(); n_chk++;
    if (rd_data[31:0] !== e) begin
      n_err++;
      $display("FAIL rst_pre_data got=%h exp=%h", rd_data[31:0], e);
    end
    rst = 1'b0;
    sbq.push_back(32'h0);
    sbq.push_back(32'h0);
    sbq.push_back(32'h0);
    sbq.push_back(32'h1);
    #1;
    e = sbq.pop_front(); n_chk++;
    if (rd_data[31:0] !== e) begin
      n_err++;
      $display("FAIL rst_data got=%h exp=%h", rd_data[31:0], e);
    end
    e = sbq.pop_front(); n_chk++;
    if (sb_err !== e[0]) begin
      n_err++;
      $display("FAIL rst_sb_err got=%b exp=%b", sb_err, e[0]);
    end
    e = sbq.pop_front(); n_chk++;
    if (hazard !== e[0]) begin
      n_err++;
      $display("FAIL rst_hazard got=%b exp=%b", hazard, e[0]);
    end
    e = sbq.pop_front(); n_chk++;
    if (issue_ready !== e[0]) begin
      n_err++;
      $display("FAIL rst_ready got=%b exp=%b", issue_ready, e[0]);
    end
    cyc();
    rst = 1'b1;
    sbq.push_back(32'h0);
    #1;
    e = sbq.pop_front(); n_chk++;
    if (rd_data[31:0] !== e) begin
      n_err++;
      $display("FAIL rst_post_data got=%h exp=%h", rd_data[31:0], e);
    end
  endtask

  task automatic test_basic_raw;
    idle();
    issue_valid = 1'b1; issue_dest = 4'd5;
    cyc();
    idle();
    rd_addr = {4'd0, 4'd0, 4'd5};
    rd_en   = 3'b001;
    sbq.push_back(32'h1);
    #1;
    e = sbq.pop_front(); n_chk++;
    if (hazard !== e[0]) begin
      n_err++;
      $display("FAIL raw_hazard got=%b exp=%b", hazard, e[0]);
    end
    wb(4'd5, 32'hDEADBEEF);
    sbq.push_back(32'hDEADBEEF);
    sbq.push_back(32'h0);
    #1;
    e = sbq.pop_front(); n_chk++;
    if (rd_data[31:0] !== e) begin
      n_err++;
      $display("FAIL raw_bypass got=%h exp=%h", rd_data[31:0], e);
    end
    e = sbq.pop_front(); n_chk++;
    if (hazard !== e[0]) begin
      n_err++;
      $display("FAIL raw_wb_hazard got=%b exp=%b", hazard, e[0]);
    end
    cyc();
    wb_en = 1'b0;
    sbq.push_back(32'hDEADBEEF);
    sbq.push_back(32'h0);
    #1;
    e = sbq.pop_front(); n_chk++;
    if (rd_data[31:0] !== e) begin
      n_err++;
      $display("FAIL raw_stored got=%h exp=%h", rd_data[31:0], e);
    end
    e = sbq.pop_front(); n_chk++;
    if (rd_pending !== e[2:0]) begin
      n_err++;
      $display("FAIL raw_cleared got=%b exp=%b", rd_pending, e[2:0]);
    end
  endtask

  task automatic test_multi_inflight;
    idle();
    issue_valid = 1'b1; issue_dest = 4'd2;
    repeat (3) cyc();
    sbq.push_back(32'h0);
    #1;
    e = sbq.pop_front(); n_chk++;
    if (issue_ready !== e[0]) begin
      n_err++;
      $display("FAIL multi_sat_ready got=%b exp=%b", issue_ready, e[0]);
    end
    cyc();
    idle();
    rd_addr = {4'd0, 4'd0, 4'd2};
    rd_en   = 3'b001;
    for (int k = 1; k <= 3; k++) begin
      wb(4'd2, 32'(k));
      sbq.push_back(k == 3 ? 32'h0 : 32'h1);
      #1;
      e = sbq.pop_front(); n_chk++;
      if (hazard !== e[0]) begin
        n_err++;
        $display("FAIL multi_wb%0d_hazard got=%b exp=%b", k, hazard, e[0]);
      end
      if (k < 3) cyc();
    end
    sbq.push_back(32'h3);
    #1;
    e = sbq.pop_front(); n_chk++;
    if (rd_data[31:0] !== e) begin
      n_err++;
      $display("FAIL multi_last_data got=%h exp=%h", rd_data[31:0], e);
    end
    cyc();
    wb_en = 1'b0;
    sbq.push_back(32'h0);
    sbq.push_back(32'h0);
    #1;
    e = sbq.pop_front(); n_chk++;
    if (hazard !== e[0]) begin
      n_err++;
      $display("FAIL multi_drained got=%b exp=%b", hazard, e[0]);
    end
    e = sbq.pop_front(); n_chk++;
    if (sb_err !== e[0]) begin
      n_err++;
      $display("FAIL multi_sb_err got=%b exp=%b", sb_err, e[0]);
    end
  endtask

  task automatic test_issue_wb_same;
    idle();
    issue_valid = 1'b1; issue_dest = 4'd6;
    cyc();
    wb(4'd6, 32'h66);
    cyc();
    idle();
    rd_addr = {4'd0, 4'd0, 4'd6};
    rd_en   = 3'b001;
    sbq.push_back(32'h1);
    #1;
    e = sbq.pop_front(); n_chk++;
    if (rd_pending !== e[2:0]) begin
      n_err++;
      $display("FAIL same_hold got=%b exp=%b", rd_pending, e[2:0]);
    end
    issue_valid = 1'b1;
    repeat (2) cyc();
    issue_valid = 1'b0;
    sbq.push_back(32'h0);
    #1;
    e = sbq.pop_front(); n_chk++;
    if (issue_ready !== e[0]) begin
      n_err++;
      $display("FAIL same_full got=%b exp=%b", issue_ready, e[0]);
    end
    wb(4'd6, 32'h67);
    sbq.push_back(32'h1);
    #1;
    e = sbq.pop_front(); n_chk++;
    if (issue_ready !== e[0]) begin
      n_err++;
      $display("FAIL same_wb_ready got=%b exp=%b", issue_ready, e[0]);
    end
    issue_valid = 1'b1;
    cyc();
    issue_valid = 1'b0;
    repeat (2) cyc();
    sbq.push_back(32'h0);
    sbq.push_back(32'h67);
    #1;
    e = sbq.pop_front(); n_chk++;
    if (rd_pending !== e[2:0]) begin
      n_err++;
      $display("FAIL same_last_pend got=%b exp=%b", rd_pending, e[2:0]);
    end
    e = sbq.pop_front(); n_chk++;
    if (rd_data[31:0] !== e) begin
      n_err++;
      $display("FAIL same_last_data got=%h exp=%h", rd_data[31:0], e);
    end
    cyc();
    wb_en = 1'b0;
    sbq.push_back(32'h0);
    #1;
    e = sbq.pop_front(); n_chk++;
    if (sb_err !== e[0]) begin
      n_err++;
      $display("FAIL same_sb_err got=%b exp=%b", sb_err, e[0]);
    end
  endtask

  task automatic test_ports;
    idle();
    issue_valid = 1'b1; issue_dest = 4'd4;
    cyc();
    idle();
    rd_addr = {4'd0, 4'd4, 4'd4};
    rd_en   = 3'b101;
    sbq.push_back(32'b001);
    sbq.push_back(32'h1);
    #1;
    e = sbq.pop_front(); n_chk++;
    if (rd_pending !== e[2:0]) begin
      n_err++;
      $display("FAIL ports_pend got=%b exp=%b", rd_pending, e[2:0]);
    end
    e = sbq.pop_front(); n_chk++;
    if (hazard !== e[0]) begin
      n_err++;
      $display("FAIL ports_hazard got=%b exp=%b", hazard, e[0]);
    end
    rd_en = 3'b100;
    sbq.push_back(32'h0);
    sbq.push_back(32'h0);
    #1;
    e = sbq.pop_front(); n_chk++;
    if (hazard !== e[0]) begin
      n_err++;
      $display("FAIL ports_off_hazard got=%b exp=%b", hazard, e[0]);
    end
    e = sbq.pop_front(); n_chk++;
    if (rd_data[95:64] !== e) begin
      n_err++;
      $display("FAIL ports_r0 got=%h exp=%h", rd_data[95:64], e);
    end
    wb(4'd4, 32'h44);
    cyc();
    idle();
  endtask

  task automatic test_flush;
    idle();
    issue_valid = 1'b1; issue_dest = 4'd1;
    cyc();
    issue_dest = 4'd7;
    cyc();
    issue_valid = 1'b0;
    rd_addr = {4'd9, 4'd7, 4'd1};
    rd_en   = 3'b111;
    sbq.push_back(32'b011);
    #1;
    e = sbq.pop_front(); n_chk++;
    if (rd_pending !== e[2:0]) begin
      n_err++;
      $display("FAIL flush_pre got=%b exp=%b", rd_pending, e[2:0]);
    end
    flush = 1'b1;
    wb(4'd9, 32'h10);
    cyc();
    idle();
    rd_en = 3'b111;
    sbq.push_back(32'b000);
    sbq.push_back(32'h10);
    sbq.push_back(32'h0);
    #1;
    e = sbq.pop_front(); n_chk++;
    if (rd_pending !== e[2:0]) begin
      n_err++;
      $display("FAIL flush_pend got=%b exp=%b", rd_pending, e[2:0]);
    end
    e = sbq.pop_front(); n_chk++;
    if (rd_data[95:64] !== e) begin
      n_err++;
      $display("FAIL flush_r9 got=%h exp=%h", rd_data[95:64], e);
    end
    e = sbq.pop_front(); n_chk++;
    if (sb_err !== e[0]) begin
      n_err++;
      $display("FAIL flush_sb_err got=%b exp=%b", sb_err, e[0]);
    end
    wb(4'd1, 32'h11);
    cyc();
    idle();
    sbq.push_back(32'h1);
    #1;
    e = sbq.pop_front(); n_chk++;
    if (sb_err !== e[0]) begin
      n_err++;
      $display("FAIL err_set got=%b exp=%b", sb_err, e[0]);
    end
    cyc();
    sbq.push_back(32'h1);
    #1;
    e = sbq.pop_front(); n_chk++;
    if (sb_err !== e[0]) begin
      n_err++;
      $display("FAIL err_sticky got=%b exp=%b", sb_err, e[0]);
    end
  endtask

  initial begin
    test_reset();
    test_basic_raw();
    test_multi_inflight();
    test_issue_wb_same();
    test_ports();
    test_flush();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
